// File: rtl/banco_registradores_wb.sv
// MIPS register file with a single-entry pending-write stage.
// A captured write-back sits in the pending register for one cycle. During that
// cycle it is bypassed onto the read ports. It commits to the array on the next edge.
module banco_registradores_wb #(
    parameter int LARGURA = 32,
    parameter int N_REGS  = 32,
    parameter int IW      = $clog2(N_REGS)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [IW-1:0]      read_reg1,
    input  logic [IW-1:0]      read_reg2,
    output logic [LARGURA-1:0] read_data1,
    output logic [LARGURA-1:0] read_data2,
    input  logic               wb_valid,
    input  logic               RegWrite,
    input  logic               RegDst,
    input  logic [IW-1:0]      rt,
    input  logic [IW-1:0]      rd,
    input  logic               MemtoReg,
    input  logic [LARGURA-1:0] saida_ALU,
    input  logic [LARGURA-1:0] dado_memoria,
    output logic               wb_pendente
);

    logic [N_REGS-1:0][LARGURA-1:0] regs_q, regs_d;
    logic                           pend_vld_q, pend_vld_d;
    logic [IW-1:0]                  pend_dest_q, pend_dest_d;
    logic [LARGURA-1:0]             pend_data_q, pend_data_d;

    logic               wr_en;
    logic [IW-1:0]      wr_dest;
    logic [LARGURA-1:0] wr_data;

    // Write-back selection: RegDst picks the destination, MemtoReg picks the source.
    always_comb begin
        wr_en   = wb_valid & RegWrite;
        wr_dest = RegDst ? rd : rt;
        wr_data = MemtoReg ? dado_memoria : saida_ALU;
    end

    // Next state: commit the old pending entry and capture the new one in parallel.
    // Writes to $0 never enter pending, so $0 is never committed or bypassed.
    always_comb begin
        regs_d = regs_q;
        if (pend_vld_q)
            regs_d[pend_dest_q] = pend_data_q;
        regs_d[0]   = '0;
        pend_vld_d  = wr_en && (wr_dest != '0);
        pend_dest_d = pend_dest_q;
        pend_data_d = pend_data_q;
        if (pend_vld_d) begin
            pend_dest_d = wr_dest;
            pend_data_d = wr_data;
        end
    end

    // State registers. An async reset clears the array and discards any pending write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_dest_q <= '0;
            pend_data_q <= '0;
        end else begin
            regs_q      <= regs_d;
            pend_vld_q  <= pend_vld_d;
            pend_dest_q <= pend_dest_d;
            pend_data_q <= pend_data_d;
        end
    end

    // Combinational read ports. $0 reads zero, and the pending entry wins over the array.
    always_comb begin
        read_data1 = regs_q[read_reg1];
        if (pend_vld_q && pend_dest_q == read_reg1)
            read_data1 = pend_data_q;
        if (read_reg1 == '0)
            read_data1 = '0;
        read_data2 = regs_q[read_reg2];
        if (pend_vld_q && pend_dest_q == read_reg2)
            read_data2 = pend_data_q;
        if (read_reg2 == '0)
            read_data2 = '0;
        wb_pendente = pend_vld_q;
    end

endmodule

// File: tb/tb_banco_registradores_wb.sv
// Directed bench for banco_registradores_wb: reset, bypass, commit, $0 and gating cases.
module tb_banco_registradores_wb;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  read_reg1, read_reg2, rt, rd;
    logic [31:0] read_data1, read_data2, saida_ALU, dado_memoria;
    logic        wb_valid, RegWrite, RegDst, MemtoReg, wb_pendente;

    int checks = 0;
    int errors = 0;

    banco_registradores_wb dut (
        .clock(clock), .reset_n(reset_n),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .wb_valid(wb_valid), .RegWrite(RegWrite), .RegDst(RegDst),
        .rt(rt), .rd(rd), .MemtoReg(MemtoReg),
        .saida_ALU(saida_ALU), .dado_memoria(dado_memoria),
        .wb_pendente(wb_pendente)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; RegWrite = 0; RegDst = 0; MemtoReg = 0;
        rt = 0; rd = 0; saida_ALU = 0; dado_memoria = 0;
    endtask

    task automatic write_rd(input logic [4:0] r, input logic [31:0] v);
        wb_valid = 1; RegWrite = 1; RegDst = 1; rd = r; rt = 5'd0;
        MemtoReg = 0; saida_ALU = v; dado_memoria = 32'h0;
    endtask

    task automatic test_reset();
        write_rd(5'd7, 32'h5555_AAAA);
        tick();
        write_rd(5'd6, 32'h1111_2222);
        tick();
        idle();
        #2 reset_n = 0;
        #3 reset_n = 1;
        #1;
        for (int i = 0; i < 32; i++) begin
            read_reg1 = i[4:0]; read_reg2 = i[4:0];
            #1;
            checks++;
            if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_read idx=%0d got %h/%h expected 0", i, read_data1, read_data2);
            end
        end
        checks++;
        if (wb_pendente !== 1'b0) begin
            errors++;
            $display("FAIL reset_pend got %b expected 0", wb_pendente);
        end
    endtask

    task automatic test_alu_write();
        tick();
        write_rd(5'd8, 32'h0000_00AF);
        read_reg1 = 5'd8; read_reg2 = 5'd8;
        tick();
        idle();
        #1;
        checks++;
        if (read_data2 !== 32'hAF || read_data1 !== 32'hAF || wb_pendente !== 1'b1) begin
            errors++;
            $display("FAIL alu_bypass got %h/%h pend=%b expected 000000af/000000af pend=1",
                     read_data1, read_data2, wb_pendente);
        end
        tick();
        checks++;
        if (read_data2 !== 32'hAF || wb_pendente !== 1'b0) begin
            errors++;
            $display("FAIL alu_commit got %h pend=%b expected 000000af pend=0", read_data2, wb_pendente);
        end
        tick();
        checks++;
        if (read_data2 !== 32'hAF) begin
            errors++;
            $display("FAIL alu_hold got %h expected 000000af", read_data2);
        end
    endtask

    task automatic test_load();
        wb_valid = 1; RegWrite = 1; RegDst = 0; rt = 5'd9; rd = 5'd4;
        MemtoReg = 1; dado_memoria = 32'hDEAD_BEEF; saida_ALU = 32'd5;
        read_reg1 = 5'd9; read_reg2 = 5'd4;
        tick();
        idle();
        #1;
        checks++;
        if (read_data1 !== 32'hDEAD_BEEF || read_data2 !== 32'h0) begin
            errors++;
            $display("FAIL load_bypass got %h/%h expected deadbeef/00000000", read_data1, read_data2);
        end
        tick();
        tick();
        checks++;
        if (read_data1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_commit got %h expected deadbeef", read_data1);
        end
    endtask

    task automatic test_zero();
        write_rd(5'd0, 32'hFFFF_FFFF);
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        tick();
        idle();
        #1;
        checks++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0 || wb_pendente !== 1'b0) begin
            errors++;
            $display("FAIL zero_bypass got %h/%h pend=%b expected 0/0 pend=0",
                     read_data1, read_data2, wb_pendente);
        end
        tick();
        checks++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_commit got %h/%h expected 0/0", read_data1, read_data2);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [4] = '{32'd1, 32'd2, 32'd2, 32'd2};
        read_reg1 = 5'd3; read_reg2 = 5'd3;
        write_rd(5'd3, 32'd1);
        tick();
        write_rd(5'd3, 32'd2);
        #1;
        checks++;
        if (read_data1 !== exp[0]) begin
            errors++;
            $display("FAIL b2b_0 got %h expected %h", read_data1, exp[0]);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            idle();
            #1;
            checks++;
            if (read_data1 !== exp[i] || read_data2 !== exp[i]) begin
                errors++;
                $display("FAIL b2b_%0d got %h/%h expected %h", i, read_data1, read_data2, exp[i]);
            end
        end
        checks++;
        if (wb_pendente !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pend got %b expected 0", wb_pendente);
        end
    endtask

    task automatic test_gating();
        read_reg1 = 5'd10; read_reg2 = 5'd11;
        wb_valid = 0; RegWrite = 1; RegDst = 1; rd = 5'd10; saida_ALU = 32'hAAAA_0001;
        tick();
        wb_valid = 1; RegWrite = 0; RegDst = 1; rd = 5'd11; saida_ALU = 32'hBBBB_0002;
        tick();
        idle();
        tick();
        checks++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0 || wb_pendente !== 1'b0) begin
            errors++;
            $display("FAIL gating got %h/%h pend=%b expected 0/0 pend=0",
                     read_data1, read_data2, wb_pendente);
        end
    endtask

    task automatic test_reset_mid_write();
        read_reg1 = 5'd5; read_reg2 = 5'd8;
        write_rd(5'd5, 32'h0000_1234);
        tick();
        idle();
        #1;
        checks++;
        if (read_data1 !== 32'h1234 || wb_pendente !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got %h pend=%b expected 00001234 pend=1", read_data1, wb_pendente);
        end
        reset_n = 0;
        #1;
        checks++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0 || wb_pendente !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got %h/%h pend=%b expected 0/0 pend=0",
                     read_data1, read_data2, wb_pendente);
        end
        reset_n = 1;
        tick();
        tick();
        checks++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            errors++;
            $display("FAIL midrst_post got %h/%h expected 0/0", read_data1, read_data2);
        end
    endtask

    initial begin
        idle();
        read_reg1 = 0; read_reg2 = 0;
        reset_n = 0;
        #12 reset_n = 1;
        tick();
        test_reset();
        test_alu_write();
        test_load();
        test_zero();
        test_back_to_back();
        test_gating();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
